// File: rtl/sha256_job_scheduler_if.sv
// Signal bundle between the SHA-256 job scheduler, its requesters and the SHA-256 core.
interface sha256_job_scheduler_if #(
    parameter int NUM_REQ = 4
);
    // Handshake: a requester raises req[i] with stable addresses and holds it until a
    // one-cycle req_ack[i] or req_err[i]; the core gets a one-cycle core_start and
    // reports idle by holding core_done high.
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ-1:0][15:0] req_message_addr;
    logic [NUM_REQ-1:0][15:0] req_output_addr;
    logic [NUM_REQ-1:0]       req_ack;
    logic [NUM_REQ-1:0]       req_err;
    logic                     core_start;
    logic [15:0]              core_message_addr;
    logic [15:0]              core_output_addr;
    logic                     core_done;

    modport master (
        input  req, req_message_addr, req_output_addr, core_done,
        output req_ack, req_err, core_start, core_message_addr, core_output_addr
    );

    modport slave (
        output req, req_message_addr, req_output_addr, core_done,
        input  req_ack, req_err, core_start, core_message_addr, core_output_addr
    );
endinterface

// File: rtl/sha256_job_scheduler.sv
// Round-robin scheduler that hands hashing jobs from NUM_REQ requesters to one
// SHA-256 core, with a start-acceptance timeout and a completed-job counter.
module sha256_job_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    sha256_job_scheduler_if.master bus,
    output logic                   busy,
    output logic [2:0]             cur_id,
    output logic [15:0]            jobs_done,
    output logic [2:0]             state_dbg
);
    localparam int            TW         = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_RUN       = 3'd3,
        S_ACK       = 3'd4,
        S_ERR       = 3'd5
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [TW-1:0]      timer;
    logic [2:0]         cur_id_q;
    logic [2:0]         last_grant;
    logic [15:0]        msg_q;
    logic [15:0]        out_q;
    logic [15:0]        jobs_done_q;
    logic [7:0]         req_ext;
    logic [7:0][15:0]   msg_ext;
    logic [7:0][15:0]   out_ext;
    logic [3:0]         cand;
    logic               grant_valid;
    logic [2:0]         grant_id;
    logic               core_start_c;
    logic               busy_c;
    logic [NUM_REQ-1:0] ack_c;
    logic [NUM_REQ-1:0] err_c;

    // Widen the request side to 8 entries so a 3-bit index is always in range.
    always_comb begin
        req_ext = '0;
        msg_ext = '0;
        out_ext = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ext[i] = bus.req[i];
            msg_ext[i] = bus.req_message_addr[i];
            out_ext[i] = bus.req_output_addr[i];
        end
    end

    // Walk offsets from farthest to nearest so the requester right after last_grant wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = {1'b0, last_grant} + 4'(i);
            if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
            if (req_ext[cand[2:0]]) begin
                grant_valid = 1'b1;
                grant_id    = cand[2:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (grant_valid && bus.core_done) state_next = S_START;
            S_START:     state_next = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (!bus.core_done)           state_next = S_RUN;
                else if (timer == TIMER_LAST) state_next = S_ERR;
            end
            S_RUN:       if (bus.core_done) state_next = S_ACK;
            S_ACK:       state_next = S_IDLE;
            S_ERR:       state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_comb begin
        core_start_c = (state == S_START);
        busy_c       = (state != S_IDLE);
        ack_c        = '0;
        err_c        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            ack_c[i] = (state == S_ACK) && (cur_id_q == 3'(i));
            err_c[i] = (state == S_ERR) && (cur_id_q == 3'(i));
        end
    end

    // Job context: addresses are captured at grant and held until the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_id_q   <= '0;
            last_grant <= 3'(NUM_REQ - 1);
            timer      <= '0;
            msg_q      <= '0;
            out_q      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_valid && bus.core_done) begin
                        cur_id_q <= grant_id;
                        msg_q    <= msg_ext[grant_id];
                        out_q    <= out_ext[grant_id];
                    end
                end
                S_START:     timer <= '0;
                S_WAIT_BUSY: begin
                    if (bus.core_done && timer != TIMER_LAST) timer <= timer + TW'(1);
                end
                S_ACK:       last_grant <= cur_id_q;
                S_ERR:       last_grant <= cur_id_q;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)               jobs_done_q <= '0;
        else if (state == S_ACK) jobs_done_q <= jobs_done_q + 16'd1;
    end

    assign bus.core_start        = core_start_c;
    assign bus.core_message_addr = msg_q;
    assign bus.core_output_addr  = out_q;
    assign bus.req_ack           = ack_c;
    assign bus.req_err           = err_c;
    assign busy                  = busy_c;
    assign cur_id                = cur_id_q;
    assign jobs_done             = jobs_done_q;
    assign state_dbg             = state;
endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Directed and randomized bench for sha256_job_scheduler with a behavioural core
// model and a transaction-level round-robin reference.
module tb_sha256_job_scheduler;
  localparam int NUM_REQ   = 4;
  localparam int TIMEOUT   = 16;
  localparam int CORE_AUTO = 0;
  localparam int CORE_HIGH = 1;
  localparam int CORE_LOW  = 2;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        busy;
  logic [2:0]  cur_id;
  logic [15:0] jobs_done;
  logic [2:0]  state_dbg;

  sha256_job_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  sha256_job_scheduler #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .bus(bus), .busy(busy),
    .cur_id(cur_id), .jobs_done(jobs_done), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no end of test, expected $finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard and reference state
  int          tests_run    = 0;
  int          tests_failed = 0;
  int          cyc          = 0;
  logic [2:0]  exp_q[$];
  int          grant_log[$];
  logic [15:0] msg_tab[NUM_REQ];
  logic [15:0] out_tab[NUM_REQ];
  int          m_last;
  logic [15:0] m_jobs;
  bit          in_job, job_to, hold_reqs, rand_phase;
  int          job_id, start_cyc, rise_cyc;
  logic [15:0] job_msg, job_out;
  int          start_cnt, ack_cnt, err_cnt;
  // core model
  int          core_mode, cm_drop, cm_hold, drop_dly, hold_len;
  logic        prev_done;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NUM_REQ-1:0] mask, input int last);
    for (int k = 1; k <= NUM_REQ; k++) begin
      int c;
      c = (last + k) % NUM_REQ;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [15:0] m, input logic [15:0] o);
    msg_tab[i] = m;
    out_tab[i] = o;
    bus.req_message_addr[i] = m;
    bus.req_output_addr[i]  = o;
    bus.req[i] = 1'b1;
  endtask

  task automatic reset_checks();
    in_job = 1'b0;
    exp_q.delete();
    m_last = NUM_REQ - 1;
    m_jobs = '0;
    check("rst_core_start", 32'(bus.core_start), 0);
    check("rst_req_ack", 32'(bus.req_ack), 0);
    check("rst_req_err", 32'(bus.req_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cur_id", 32'(cur_id), 0);
    check("rst_jobs_done", 32'(jobs_done), 0);
    check("rst_msg_addr", 32'(bus.core_message_addr), 0);
    check("rst_out_addr", 32'(bus.core_output_addr), 0);
  endtask

  task automatic monitor();
    logic [NUM_REQ-1:0] fired, oh;
    logic [2:0]         e;
    int                 id;
    if (bus.core_start) begin
      id = rr_pick(bus.req, m_last);
      check("start_single", 32'(in_job), 0);
      check("start_core_idle", 32'(prev_done), 1);
      check("start_has_req", 32'(id >= 0), 1);
      if (id < 0) id = 0;
      job_id  = id;
      job_msg = msg_tab[id];
      job_out = out_tab[id];
      check("grant_id", 32'(cur_id), 32'(id));
      check("grant_msg", 32'(bus.core_message_addr), 32'(job_msg));
      check("grant_out", 32'(bus.core_output_addr), 32'(job_out));
      exp_q.push_back(3'(id));
      grant_log.push_back(int'(cur_id));
      in_job    = 1'b1;
      start_cyc = cyc;
      start_cnt++;
      if (rand_phase) begin
        drop_dly = $urandom_range(0, 4);
        hold_len = $urandom_range(2, 12);
        if ($urandom_range(0, 5) == 0) core_mode = CORE_HIGH;
        if ($urandom_range(0, 3) == 0) bus.req[id] = 1'b0;
        if ($urandom_range(0, 1) == 0) begin
          msg_tab[id] = 16'($urandom_range(0, 16'hFFFF));
          out_tab[id] = 16'($urandom_range(0, 16'hFFFF));
          bus.req_message_addr[id] = msg_tab[id];
          bus.req_output_addr[id]  = out_tab[id];
        end
      end
      job_to = (core_mode == CORE_HIGH);
    end
    check("busy", 32'(busy), 32'(in_job));
    if (in_job) begin
      check("hold_cur_id", 32'(cur_id), 32'(job_id));
      check("hold_msg", 32'(bus.core_message_addr), 32'(job_msg));
      check("hold_out", 32'(bus.core_output_addr), 32'(job_out));
    end
    fired = bus.req_ack | bus.req_err;
    check("pulse_onehot0", 32'($onehot0(fired)), 1);
    check("jobs_done", 32'(jobs_done), 32'(m_jobs));
    if (fired != '0) begin
      check("pulse_in_job", 32'(in_job), 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd7;
      oh = '0;
      if (int'(e) < NUM_REQ) oh[e] = 1'b1;
      check("pulse_id", 32'(fired), 32'(oh));
      if (job_to) begin
        check("err_pulse", 32'(bus.req_err), 32'(oh));
        check("err_time", 32'(cyc), 32'(start_cyc + 1 + TIMEOUT));
        err_cnt++;
        core_mode = CORE_AUTO;
      end else begin
        check("ack_pulse", 32'(bus.req_ack), 32'(oh));
        check("ack_time", 32'(cyc), 32'(rise_cyc + 1));
        ack_cnt++;
        m_jobs++;
      end
      m_last = job_id;
      in_job = 1'b0;
      if (!hold_reqs) bus.req[job_id] = 1'b0;
    end
  endtask

  task automatic core_step();
    case (core_mode)
      CORE_HIGH: begin bus.core_done = 1'b1; cm_drop = -1; cm_hold = 0; end
      CORE_LOW:  begin bus.core_done = 1'b0; cm_drop = -1; cm_hold = 0; end
      default: begin
        if (!bus.core_done) begin
          if (cm_hold > 1) cm_hold--;
          else begin
            cm_hold = 0;
            bus.core_done = 1'b1;
            rise_cyc = cyc;
          end
        end
        if (bus.core_start) cm_drop = drop_dly;
        if (cm_drop == 0) begin
          bus.core_done = 1'b0;
          cm_hold = hold_len;
          cm_drop = -1;
        end else if (cm_drop > 0) begin
          cm_drop--;
        end
      end
    endcase
    prev_done = bus.core_done;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (reset) reset_checks();
    else       monitor();
    core_step();
  endtask

  task automatic run_until_quiet(input int budget, input string tag);
    int n;
    n = 0;
    while ((bus.req != '0 || in_job) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_quiet"}, 32'(bus.req == '0 && !in_job), 1);
    repeat (2) tick();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) tick();
    reset = 1'b0;
  endtask

  initial begin
    int base_start, base_ack, base_err, n;
    int fair_exp[5];
    fair_exp = '{0, 1, 2, 3, 0};
    bus.req = '0;
    bus.req_message_addr = '0;
    bus.req_output_addr  = '0;
    bus.core_done = 1'b1;
    prev_done = 1'b1;
    core_mode = CORE_AUTO;
    cm_drop = -1; cm_hold = 0; drop_dly = 0; hold_len = 4;
    hold_reqs = 1'b0; rand_phase = 1'b0;
    start_cnt = 0; ack_cnt = 0; err_cnt = 0; rise_cyc = 0;
    do_reset(3);

    // single job with a long core run
    hold_len = 170;
    base_start = start_cnt; base_ack = ack_cnt;
    set_req(0, 16'h0000, 16'h0100);
    run_until_quiet(400, "single");
    check("single_starts", 32'(start_cnt - base_start), 1);
    check("single_acks", 32'(ack_cnt - base_ack), 1);
    check("single_jobs", 32'(jobs_done), 1);

    // fairness with all requests held continuously
    do_reset(2);
    hold_len = 4;
    grant_log.delete();
    hold_reqs = 1'b1;
    base_ack = ack_cnt;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)));
    n = 0;
    while (ack_cnt - base_ack < 5 && n < 300) begin tick(); n++; end
    bus.req = '0;
    hold_reqs = 1'b0;
    check("fair_acks", 32'(ack_cnt - base_ack), 5);
    for (int k = 0; k < 5; k++)
      check("fair_order", 32'((k < grant_log.size()) ? grant_log[k] : -1), 32'(fair_exp[k]));
    run_until_quiet(100, "fair_tail");
    check("fair_jobs", 32'(jobs_done), 5);

    // timeout: core never leaves idle
    do_reset(2);
    core_mode = CORE_HIGH;
    base_start = start_cnt; base_err = err_cnt;
    set_req(2, 16'h1234, 16'h5678);
    run_until_quiet(100, "timeout");
    check("to_starts", 32'(start_cnt - base_start), 1);
    check("to_errs", 32'(err_cnt - base_err), 1);
    check("to_jobs", 32'(jobs_done), 0);
    hold_len = 6;
    base_ack = ack_cnt;
    set_req(3, 16'h0abc, 16'h0def);
    run_until_quiet(100, "after_to");
    check("after_to_acks", 32'(ack_cnt - base_ack), 1);
    check("after_to_jobs", 32'(jobs_done), 1);

    // core busy when the request arrives
    core_mode = CORE_LOW;
    repeat (2) tick();
    base_start = start_cnt;
    set_req(1, 16'h2222, 16'h3333);
    repeat (10) tick();
    check("core_busy_no_start", 32'(start_cnt - base_start), 0);
    core_mode = CORE_AUTO;
    hold_len = 5;
    run_until_quiet(100, "core_busy");
    check("core_busy_starts", 32'(start_cnt - base_start), 1);
    check("core_busy_grant", 32'((grant_log.size() > 0) ? grant_log[grant_log.size() - 1] : -1), 1);

    // reset while the core is running
    hold_len = 40;
    base_start = start_cnt;
    set_req(0, 16'h4444, 16'h5555);
    n = 0;
    while (!in_job && n < 20) begin tick(); n++; end
    repeat (6) tick();
    check("rst_mid_busy_before", 32'(busy), 1);
    base_ack = ack_cnt; base_err = err_cnt;
    do_reset(1);
    tick();
    check("rst_mid_no_ack", 32'(ack_cnt - base_ack), 0);
    check("rst_mid_no_err", 32'(err_cnt - base_err), 0);
    check("rst_mid_busy_after", 32'(busy), 0);
    run_until_quiet(200, "rst_mid");
    check("rst_mid_restart", 32'(start_cnt - base_start), 2);
    check("rst_mid_acks", 32'(ack_cnt - base_ack), 1);
    check("rst_mid_jobs", 32'(jobs_done), 1);

    // randomized traffic
    rand_phase = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < NUM_REQ; i++)
        if (!bus.req[i] && !(in_job && job_id == i) && $urandom_range(0, 15) == 0)
          set_req(i, 16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)));
    end
    rand_phase = 1'b0;
    drop_dly = 0;
    hold_len = 4;
    run_until_quiet(2000, "rand_drain");
    check("rand_exp_q_empty", 32'(exp_q.size()), 0);

    // counter wrap from a preloaded 0xFFFF
    force dut.jobs_done_q = 16'hFFFF;
    m_jobs = 16'hFFFF;
    tick();
    release dut.jobs_done_q;
    hold_len = 3;
    set_req(2, 16'h7777, 16'h8888);
    run_until_quiet(100, "wrap");
    check("wrap_zero", 32'(jobs_done), 32'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
